// File: rtl/neural_bp_pkg.sv
// Shared types and helpers for the perceptron branch predictor.
//   bp_state_t    : training FSM states (IDLE, READ, WRITE)
//   sum_w         : width of a dot-product sum that cannot overflow
//   theta_default : training threshold floor(1.93*hist_len + 14)
//   sat_add       : add and clamp to a signed weight_w-bit range
package neural_bp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } bp_state_t;

  function automatic int sum_w(input int weight_w, input int hist_len);
    return weight_w + $clog2(hist_len + 1) + 1;
  endfunction

  function automatic int theta_default(input int hist_len);
    return (193 * hist_len) / 100 + 14;
  endfunction

  function automatic int sat_add(input int w, input int delta, input int weight_w);
    int hi;
    int lo;
    int s;
    hi = (32'sd1 <<< (weight_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (weight_w - 1));
    s  = w + delta;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/perceptron_dot.sv
// Combinational signed dot product of one perceptron row with a history vector.
//   row  : HIST_LEN+1 packed weights, weight 0 (bias) in the low bits
//   hist : history bits, 1 means +1 and 0 means -1
//   y    : bias + sum of +/- weights, sign-extended to SUM_W bits
module perceptron_dot
  import neural_bp_pkg::*;
#(
  parameter int HIST_LEN = 16,
  parameter int WEIGHT_W = 8,
  parameter int SUM_W    = sum_w(WEIGHT_W, HIST_LEN)
) (
  input  logic [(HIST_LEN+1)*WEIGHT_W-1:0] row,
  input  logic [HIST_LEN-1:0]              hist,
  output logic signed [SUM_W-1:0]          y
);

  function automatic logic signed [SUM_W-1:0] ext(input logic [WEIGHT_W-1:0] w);
    return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  logic signed [SUM_W-1:0] acc_s;
  logic signed [SUM_W-1:0] term_s;

  // Accumulate bias, then add or subtract each weight depending on its history bit.
  always_comb begin
    acc_s  = ext(row[WEIGHT_W-1:0]);
    term_s = {SUM_W{1'b0}};
    for (int i = 0; i < HIST_LEN; i++) begin
      term_s = ext(row[(i+1)*WEIGHT_W +: WEIGHT_W]);
      if (hist[i]) begin
        acc_s = acc_s + term_s;
      end else begin
        acc_s = acc_s - term_s;
      end
    end
  end

  assign y = acc_s;

endmodule

// File: rtl/perceptron_predictor_gshare.sv
// Perceptron branch predictor with PC^GHR hashing and a speculative GHR.
//   CLK, RES                        : clock, async active-high reset
//   pred_req/pred_pc                : prediction request from fetch
//   pred_valid/pred_taken/pred_hist : prediction one cycle later + GHR used
//   upd_valid/upd_ready/upd_*       : resolved-branch training handshake
//   mispredict_cnt                  : accepted mispredicting updates (wraps)
module perceptron_predictor_gshare
  import neural_bp_pkg::*;
#(
  parameter int HIST_LEN = 16,
  parameter int IDX_BITS = 6,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = theta_default(HIST_LEN),
  parameter int HASH_EN  = 1
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [HIST_LEN-1:0] pred_hist,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [31:0]         upd_pc,
  input  logic [HIST_LEN-1:0] upd_hist,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [31:0]         mispredict_cnt
);

  localparam int ROWS  = 1 << IDX_BITS;
  localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
  localparam int SUM_W = sum_w(WEIGHT_W, HIST_LEN);

  function automatic logic [IDX_BITS-1:0] row_idx(input logic [IDX_BITS-1:0] pc_bits,
                                                  input logic [IDX_BITS-1:0] h_bits);
    if (HASH_EN != 0) begin
      return pc_bits ^ h_bits;
    end else begin
      return pc_bits;
    end
  endfunction

  logic [ROW_W-1:0]        w_r [ROWS];
  logic [HIST_LEN-1:0]     ghr_r;
  bp_state_t               state_r;
  bp_state_t               state_s;
  logic [IDX_BITS-1:0]     upd_idx_r;
  logic [HIST_LEN-1:0]     upd_hist_r;
  logic                    upd_taken_r;
  logic                    upd_mis_r;
  logic                    train_r;
  logic                    upd_ready_r;
  logic                    pred_valid_r;
  logic                    pred_taken_r;
  logic [HIST_LEN-1:0]     pred_hist_r;
  logic [31:0]             cnt_r;
  logic                    accept_s;
  logic [IDX_BITS-1:0]     pred_idx_s;
  logic signed [SUM_W-1:0] y_pred_s;
  logic                    pred_dir_s;
  logic [ROW_W-1:0]        train_row_s;
  logic signed [SUM_W-1:0] y_train_s;
  logic signed [SUM_W-1:0] y_abs_s;
  logic                    train_s;
  logic [ROW_W-1:0]        new_row_s;
  int                      new_w_s;
  int                      delta_s;
  logic                    unused_pc_s;

  assign unused_pc_s = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0], upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  assign accept_s   = upd_valid && upd_ready_r;
  assign pred_idx_s = row_idx(pred_pc[IDX_BITS+1:2], ghr_r[IDX_BITS-1:0]);

  perceptron_dot #(.HIST_LEN(HIST_LEN), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W)) u_dot_pred (
    .row  (w_r[pred_idx_s]),
    .hist (ghr_r),
    .y    (y_pred_s)
  );

  // Weights are only written in WRITE, so the row read in READ is still current there.
  assign train_row_s = w_r[upd_idx_r];

  perceptron_dot #(.HIST_LEN(HIST_LEN), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W)) u_dot_train (
    .row  (train_row_s),
    .hist (upd_hist_r),
    .y    (y_train_s)
  );

  assign pred_dir_s = ~y_pred_s[SUM_W-1];
  assign y_abs_s    = y_train_s[SUM_W-1] ? -y_train_s : y_train_s;
  assign train_s    = upd_mis_r || (y_abs_s <= SUM_W'(THETA));

  // Next-state logic for the fixed three-cycle training sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (upd_valid) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ:    state_s = WRITE;
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Trained row: each weight moves one step toward agreement with the outcome.
  always_comb begin
    new_row_s = train_row_s;
    delta_s   = 32'sd0;
    new_w_s   = 32'sd0;
    if (upd_taken_r) begin
      delta_s = 32'sd1;
    end else begin
      delta_s = -32'sd1;
    end
    new_w_s = sat_add(int'($signed(train_row_s[WEIGHT_W-1:0])), delta_s, WEIGHT_W);
    new_row_s[WEIGHT_W-1:0] = WEIGHT_W'(new_w_s);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (upd_hist_r[i] == upd_taken_r) begin
        delta_s = 32'sd1;
      end else begin
        delta_s = -32'sd1;
      end
      new_w_s = sat_add(int'($signed(train_row_s[(i+1)*WEIGHT_W +: WEIGHT_W])), delta_s, WEIGHT_W);
      new_row_s[(i+1)*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(new_w_s);
    end
  end

  // FSM state, ready flag and captured update fields.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r     <= IDLE;
      upd_ready_r <= 1'b1;
      upd_idx_r   <= {IDX_BITS{1'b0}};
      upd_hist_r  <= {HIST_LEN{1'b0}};
      upd_taken_r <= 1'b0;
      upd_mis_r   <= 1'b0;
      train_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      upd_ready_r <= (state_s == IDLE);
      if (accept_s) begin
        upd_idx_r   <= row_idx(upd_pc[IDX_BITS+1:2], upd_hist[IDX_BITS-1:0]);
        upd_hist_r  <= upd_hist;
        upd_taken_r <= upd_taken;
        upd_mis_r   <= upd_mispredict;
      end else begin
        upd_idx_r   <= upd_idx_r;
        upd_hist_r  <= upd_hist_r;
        upd_taken_r <= upd_taken_r;
        upd_mis_r   <= upd_mis_r;
      end
      if (state_r == READ) begin
        train_r <= train_s;
      end else begin
        train_r <= train_r;
      end
    end
  end

  // Weight table; a row is rewritten only at the end of WRITE when training.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int r = 0; r < ROWS; r++) begin
        w_r[r] <= {ROW_W{1'b0}};
      end
    end else if ((state_r == WRITE) && train_r) begin
      w_r[upd_idx_r] <= new_row_s;
    end else begin
      w_r <= w_r;
    end
  end

  // GHR: repair from a mispredicting update wins over a speculative shift.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ghr_r <= {HIST_LEN{1'b0}};
    end else if (accept_s && upd_mispredict) begin
      ghr_r <= {upd_hist[HIST_LEN-2:0], upd_taken};
    end else if (pred_req) begin
      ghr_r <= {ghr_r[HIST_LEN-2:0], pred_dir_s};
    end else begin
      ghr_r <= ghr_r;
    end
  end

  // Prediction output registers and mispredict counter.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_hist_r  <= {HIST_LEN{1'b0}};
      cnt_r        <= 32'd0;
    end else begin
      pred_valid_r <= pred_req;
      if (pred_req) begin
        pred_taken_r <= pred_dir_s;
        pred_hist_r  <= ghr_r;
      end else begin
        pred_taken_r <= pred_taken_r;
        pred_hist_r  <= pred_hist_r;
      end
      if (accept_s && upd_mispredict) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign pred_valid     = pred_valid_r;
  assign pred_taken     = pred_taken_r;
  assign pred_hist      = pred_hist_r;
  assign upd_ready      = upd_ready_r;
  assign mispredict_cnt = cnt_r;

endmodule
